multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Owns the stage state register for the multi-cycle CPU.
- Each cycle it drives the current stage (IF/ID/EX/MEM/WB) to the control unit, and it generates the per-stage strobes: IR load, PC write, memory request, register-file writes.
- Runs a ready/request handshake with the single shared instruction/data memory. IF and MEM wait for ready, so one shared memory port serves both.
- Supports halting at instruction boundaries and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps).
- MAX_OPC, 6'h10, highest legal opcode; opcodes above it are illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- opcode  in  6  opcode field of the instruction register; stable from the cycle after IR load.
- mem_ready  in  1  memory completes the current request this cycle.
- halt_req  in  1  request to stop at the next instruction boundary.
- state  out  3  current stage: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  write the PC (source chosen by control unit).
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- rf_we1  out  1  register-file write port 1 enable.
- rf_we2  out  1  register-file write port 2 enable (post-increment base).
- retire  out  1  one-cycle pulse: instruction completed.
- illegal  out  1  one-cycle pulse: illegal opcode retired.
- retire_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0: state=IF, retire_count=0.
  - All strobes are 0 in the reset cycle.
  - Reset mid-instruction abandons the instruction: no write strobe, no retire.
- Registered signals: the state register and retire_count only. All strobes are combinational from state, opcode and mem_ready.
- IF:
  - mem_req=1, mem_we=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC+1), next=ID.
  - Otherwise stay in IF.
- ID:
  - opcode=0x0C (JMP): pc_write=1, retire, next=IF.
  - Otherwise next=EX.
- EX:
  - opcode 0x00–0x04 (ALU/immediate): next=WB.
  - opcode 0x05, 0x06, 0x07, 0x0D, 0x0E, 0x0F, 0x10 (memory, call, ret, push, pop): next=MEM.
  - opcode 0x08–0x0B (branches): pc_write=1, retire, next=IF. The PC source selects taken or not-taken.
  - opcode 0x11–0x3F: retire and illegal pulse, no writes, next=IF.
- MEM:
  - mem_req=1.
  - mem_we=1 for opcode 0x07, 0x0D, 0x0F; otherwise 0.
  - Stay in MEM until mem_ready=1.
  - On mem_ready with opcode 0x05, 0x06, 0x10: next=WB.
  - On mem_ready otherwise: retire, next=IF. Also pc_write=1 if opcode 0x0D or 0x0E.
- WB:
  - rf_we1=1; rf_we2=1 only for opcode 0x06.
  - retire, next=IF.
- Retire and boundary rules:
  - retire_count increments by 1 on each retire, wrapping at 2^CNT_W.
  - Every transition into IF is an instruction boundary.
- Halt:
  - If halt_req=1 in a boundary cycle, next=HALT instead of IF. The retire for that instruction still counts.
  - HALT: no strobes; leave to IF on the first cycle halt_req=0.
  - halt_req is ignored in all non-boundary cycles.
- Memory handshake:
  - mem_ready is ignored when mem_req=0.
  - mem_req stays high with constant mem_we until mem_ready.
  - mem_ready asserted in the same cycle as mem_req is allowed: zero wait states, one cycle in IF/MEM.
- Latency: JMP 2 cycles; branch 3; ALU 4; SW/CALL/RET/PUSH 4; LW/LWPOI/POP 5 (each +wait states).

Decomposition:
- Shared package cpu_pkg holds:
  - stage encodings IF_STAGE..WB_STAGE, HALT_STAGE;
  - opcode constants OP_AND..OP_POP (0x00–0x10);
  - class helper functions is_alu, is_branch, needs_mem, needs_wb, is_mem_write.
  - The control unit reuses the same package.
- One sub-module, retire_counter (CNT_W counter with synchronous active-low clear and increment enable).

Test Plan:
- Reset held 3 cycles then released, ALU opcode 0x00, mem_ready=1 always:
  - states IF,ID,EX,WB,IF.
  - rf_we1 only in WB; retire_count=1 after 4 cycles.
- LW 0x05 with mem_ready delayed 2 cycles in both IF and MEM:
  - 3 IF cycles, 3 MEM cycles with mem_req=1, mem_we=0, then WB.
  - 9 cycles total.
- SW 0x07, then LWPOI 0x06:
  - SW: mem_we=1 in MEM, no rf_we, retires from MEM.
  - LWPOI: rf_we1=rf_we2=1 in WB.
- JMP 0x0C, then BEQ 0x08:
  - JMP: pc_write in ID, retire after 2 cycles.
  - BEQ: pc_write in EX, retire after 3 cycles.
- halt_req=1 raised mid-EX of an ALU instruction:
  - completes WB, then HALT, no strobes.
  - Drop halt_req: IF next cycle.
  - retire_count incremented once.
- Opcode 0x3F (illegal), then rst_n=0 asserted during MEM of a POP:
  - illegal: illegal pulse in EX, no writes.
  - reset: state=IF next cycle, no rf_we, retire_count=0.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Stage encodings, opcode map and opcode-class helpers shared by the
//            multi-cycle sequencer and the control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    IF_STAGE   = 3'd0,
    ID_STAGE   = 3'd1,
    EX_STAGE   = 3'd2,
    MEM_STAGE  = 3'd3,
    WB_STAGE   = 3'd4,
    HALT_STAGE = 3'd5
  } stage_t;

  localparam logic [5:0] OP_AND   = 6'h00;
  localparam logic [5:0] OP_OR    = 6'h01;
  localparam logic [5:0] OP_ADD   = 6'h02;
  localparam logic [5:0] OP_SUB   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h05;
  localparam logic [5:0] OP_LWPOI = 6'h06;
  localparam logic [5:0] OP_SW    = 6'h07;
  localparam logic [5:0] OP_BEQ   = 6'h08;
  localparam logic [5:0] OP_BNE   = 6'h09;
  localparam logic [5:0] OP_BLT   = 6'h0A;
  localparam logic [5:0] OP_BGE   = 6'h0B;
  localparam logic [5:0] OP_JMP   = 6'h0C;
  localparam logic [5:0] OP_CALL  = 6'h0D;
  localparam logic [5:0] OP_RET   = 6'h0E;
  localparam logic [5:0] OP_PUSH  = 6'h0F;
  localparam logic [5:0] OP_POP   = 6'h10;

  function automatic logic is_alu(input logic [5:0] op);
    return op <= OP_ADDI;
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGE);
  endfunction

  function automatic logic needs_mem(input logic [5:0] op);
    logic r;
    case (op)
      OP_LW, OP_LWPOI, OP_SW, OP_CALL, OP_RET, OP_PUSH, OP_POP: r = 1'b1;
      default:                                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // True for every opcode that finishes with a register-file write.
  function automatic logic needs_wb(input logic [5:0] op);
    return is_alu(op) || (op == OP_LW) || (op == OP_LWPOI) || (op == OP_POP);
  endfunction

  function automatic logic is_mem_write(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_CALL) || (op == OP_PUSH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_sequencer_if.sv
// ============================================================================
// Module   : multicycle_sequencer_if
// Purpose  : Sequencer-to-datapath/memory signal bundle with modports.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             halt_req;
  logic [2:0]       state;
  logic             ir_write;
  logic             pc_write;
  logic             mem_req;
  logic             mem_we;
  logic             rf_we1;
  logic             rf_we2;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] retire_count;

  modport master (
    input  opcode, mem_ready, halt_req,
    output state, ir_write, pc_write, mem_req, mem_we,
           rf_we1, rf_we2, retire, illegal, retire_count
  );

  modport slave (
    output opcode, mem_ready, halt_req,
    input  state, ir_write, pc_write, mem_req, mem_we,
           rf_we1, rf_we2, retire, illegal, retire_count
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_sequencer_retire_counter.sv
// ============================================================================
// Module   : retire_counter
// Purpose  : Wrapping retired-instruction counter, synchronous active-low clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Stage register and per-stage strobes for the multi-cycle CPU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int         CNT_W   = 16,
  parameter logic [5:0] MAX_OPC = 6'h10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_sequencer_if.master  bus
);

  stage_t           r_state;
  stage_t           w_next;
  logic             w_ir_write;
  logic             w_pc_write;
  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_rf_we1;
  logic             w_rf_we2;
  logic             w_illegal;
  logic             w_boundary;
  logic [CNT_W-1:0] w_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IF_STAGE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ir_write = 1'b0;
    w_pc_write = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_rf_we1   = 1'b0;
    w_rf_we2   = 1'b0;
    w_illegal  = 1'b0;
    w_boundary = 1'b0;

    case (r_state)
      IF_STAGE: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = ID_STAGE;
        end
      end
      ID_STAGE: begin
        if (bus.opcode == OP_JMP) begin
          w_pc_write = 1'b1;
          w_boundary = 1'b1;
        end else begin
          w_next = EX_STAGE;
        end
      end
      EX_STAGE: begin
        if (is_alu(bus.opcode)) begin
          w_next = WB_STAGE;
        end else if (needs_mem(bus.opcode)) begin
          w_next = MEM_STAGE;
        end else if (is_branch(bus.opcode)) begin
          w_pc_write = 1'b1;
          w_boundary = 1'b1;
        end else begin
          // Illegal opcodes retire without touching any architectural state.
          w_illegal  = bus.opcode > MAX_OPC;
          w_boundary = 1'b1;
        end
      end
      MEM_STAGE: begin
        w_mem_req = 1'b1;
        w_mem_we  = is_mem_write(bus.opcode);
        if (bus.mem_ready) begin
          if (needs_wb(bus.opcode)) begin
            w_next = WB_STAGE;
          end else begin
            w_pc_write = (bus.opcode == OP_CALL) || (bus.opcode == OP_RET);
            w_boundary = 1'b1;
          end
        end
      end
      WB_STAGE: begin
        w_rf_we1   = 1'b1;
        w_rf_we2   = bus.opcode == OP_LWPOI;
        w_boundary = 1'b1;
      end
      HALT_STAGE: begin
        if (!bus.halt_req) begin
          w_next = IF_STAGE;
        end
      end
      default: begin
        w_next = IF_STAGE;
      end
    endcase

    // halt_req only matters when the current instruction completes.
    if (w_boundary) begin
      w_next = bus.halt_req ? HALT_STAGE : IF_STAGE;
    end
  end

  // Reset abandons the in-flight instruction, so every strobe is masked.
  assign bus.state    = r_state;
  assign bus.ir_write = rst_n & w_ir_write;
  assign bus.pc_write = rst_n & w_pc_write;
  assign bus.mem_req  = rst_n & w_mem_req;
  assign bus.mem_we   = rst_n & w_mem_we;
  assign bus.rf_we1   = rst_n & w_rf_we1;
  assign bus.rf_we2   = rst_n & w_rf_we2;
  assign bus.retire   = rst_n & w_boundary;
  assign bus.illegal  = rst_n & w_illegal;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (bus.retire),
    .o_count (w_count)
  );

  assign bus.retire_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module   : tb_multicycle_sequencer
// Purpose  : Per-instruction cycle-script model of the sequencer, compared
//            against the DUT every cycle under directed and random opcodes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(16)) bus ();

  multicycle_sequencer #(
    .CNT_W   (16),
    .MAX_OPC (6'h10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] st;
    logic rdy, hreq, rstn;
    logic irw, pcw, mreq, mwe, we1, we2, ret, ill;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 0;
  int   m_count = 0;
  bit   lit_pending = 0;
  bit   lit_en = 0;
  int   lit_st = 0;
  int   lit_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",        32'(bus.state),        32'(cur.st));
      chk("ir_write",     32'(bus.ir_write),     32'(cur.irw));
      chk("pc_write",     32'(bus.pc_write),     32'(cur.pcw));
      chk("mem_req",      32'(bus.mem_req),      32'(cur.mreq));
      chk("mem_we",       32'(bus.mem_we),       32'(cur.mwe));
      chk("rf_we1",       32'(bus.rf_we1),       32'(cur.we1));
      chk("rf_we2",       32'(bus.rf_we2),       32'(cur.we2));
      chk("retire",       32'(bus.retire),       32'(cur.ret));
      chk("illegal",      32'(bus.illegal),      32'(cur.ill));
      chk("retire_count", 32'(bus.retire_count), m_count & 32'hFFFF);
      if (lit_en) begin
        chk("lit_state", 32'(bus.state),        lit_st);
        chk("lit_count", 32'(bus.retire_count), lit_cnt);
      end
    end
  end

  function automatic cyc_t mk(input logic [2:0] st, input logic rdy);
    cyc_t c;
    c.st   = st;
    c.rdy  = rdy;
    c.hreq = 1'($urandom_range(0, 1));
    c.rstn = 1'b1;
    c.irw  = 1'b0;
    c.pcw  = 1'b0;
    c.mreq = 1'b0;
    c.mwe  = 1'b0;
    c.we1  = 1'b0;
    c.we2  = 1'b0;
    c.ret  = 1'b0;
    c.ill  = 1'b0;
    return c;
  endfunction

  // Script of every cycle one instruction takes, derived from its opcode class.
  task automatic add_instr(input logic [5:0] op, input int if_wait, input int mem_wait,
                           input bit do_halt, input int halt_len);
    cyc_t c;
    bit is_jmp  = (op == 6'h0C);
    bit is_br   = (op >= 6'h08) && (op <= 6'h0B);
    bit is_alu  = (op <= 6'h04);
    bit ld_wb   = (op == 6'h05) || (op == 6'h06) || (op == 6'h10);
    bit st_only = (op == 6'h07) || ((op >= 6'h0D) && (op <= 6'h0F));
    bit is_ill  = (op > 6'h10);
    bit wr      = (op == 6'h07) || (op == 6'h0D) || (op == 6'h0F);
    for (int i = 0; i < if_wait; i++) begin
      c = mk(3'd0, 1'b0); c.mreq = 1'b1; plan.push_back(c);
    end
    c = mk(3'd0, 1'b1); c.mreq = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; plan.push_back(c);
    c = mk(3'd1, 1'($urandom_range(0, 1)));
    if (is_jmp) begin
      c.pcw = 1'b1; c.ret = 1'b1; plan.push_back(c);
    end else begin
      plan.push_back(c);
      c = mk(3'd2, 1'($urandom_range(0, 1)));
      if (is_br) begin
        c.pcw = 1'b1; c.ret = 1'b1; plan.push_back(c);
      end else if (is_ill) begin
        c.ret = 1'b1; c.ill = 1'b1; plan.push_back(c);
      end else begin
        plan.push_back(c);
        if (ld_wb || st_only) begin
          for (int i = 0; i < mem_wait; i++) begin
            c = mk(3'd3, 1'b0); c.mreq = 1'b1; c.mwe = wr; plan.push_back(c);
          end
          c = mk(3'd3, 1'b1); c.mreq = 1'b1; c.mwe = wr;
          if (st_only) begin
            c.ret = 1'b1; c.pcw = (op == 6'h0D) || (op == 6'h0E);
          end
          plan.push_back(c);
        end
        if (is_alu || ld_wb) begin
          c = mk(3'd4, 1'($urandom_range(0, 1)));
          c.we1 = 1'b1; c.we2 = (op == 6'h06); c.ret = 1'b1; plan.push_back(c);
        end
      end
    end
    c = plan[plan.size()-1];
    c.hreq = do_halt;
    plan[plan.size()-1] = c;
    if (do_halt) begin
      for (int i = 0; i < halt_len; i++) begin
        c = mk(3'd5, 1'($urandom_range(0, 1)));
        c.hreq = (i < halt_len - 1);
        plan.push_back(c);
      end
    end
  endtask

  task automatic run_plan(input logic [5:0] op);
    while (plan.size() > 0) begin
      cur           = plan.pop_front();
      bus.opcode    = op;
      bus.mem_ready = cur.rdy;
      bus.halt_req  = cur.hreq;
      rst_n         = cur.rstn;
      lit_en        = lit_pending;
      lit_pending   = 0;
      chk_en        = 1;
      @(posedge clk);
      if (!cur.rstn) m_count = 0;
      else if (cur.ret) m_count++;
      #1;
    end
  endtask

  task automatic lit_next(input int s, input int c);
    lit_pending = 1;
    lit_st      = s;
    lit_cnt     = c;
  endtask

  initial begin
    cyc_t c;
    logic [5:0] op;
    rst_n         = 1'b0;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    bus.halt_req  = 1'b0;
    @(posedge clk);
    #1;
    // Two further reset cycles with active-looking inputs: strobes must stay low.
    for (int i = 0; i < 2; i++) begin
      c = mk(3'd0, 1'b1); c.rstn = 1'b0; plan.push_back(c);
    end
    lit_next(0, 0);
    run_plan(6'h00);

    add_instr(6'h00, 0, 0, 0, 0); run_plan(6'h00);
    lit_next(0, 1);
    add_instr(6'h05, 2, 2, 0, 0); run_plan(6'h05);
    lit_next(0, 2);
    add_instr(6'h07, 0, 0, 0, 0); run_plan(6'h07);
    add_instr(6'h06, 0, 0, 0, 0); run_plan(6'h06);
    lit_next(0, 4);
    add_instr(6'h0C, 0, 0, 0, 0); run_plan(6'h0C);
    add_instr(6'h08, 0, 0, 0, 0); run_plan(6'h08);
    lit_next(0, 6);
    add_instr(6'h02, 0, 0, 1, 3); run_plan(6'h02);
    lit_next(0, 7);
    add_instr(6'h3F, 0, 0, 0, 0); run_plan(6'h3F);
    lit_next(0, 8);

    // POP interrupted by reset during its second MEM wait cycle.
    add_instr(6'h10, 0, 3, 0, 0);
    while (plan.size() > 5) void'(plan.pop_back());
    c = plan[4];
    c.rstn = 1'b0; c.mreq = 1'b0; c.mwe = 1'b0;
    plan[4] = c;
    run_plan(6'h10);
    lit_next(0, 0);

    for (int n = 0; n < 300; n++) begin
      op = 6'($urandom_range(0, 63));
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
      run_plan(op);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
